// File: rtl/tunnel_pkg.sv
// Shared defaults, row entry layout and FSM encoding for the tunnel row generator.
package tunnel_pkg;

   localparam int COLS_DEF      = 80;
   localparam int MIN_WIDTH_DEF = 16;
   localparam int MAX_WIDTH_DEF = 48;
   localparam int DEPTH_DEF     = 4;
   localparam int ROW_W         = 15;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_COMPUTE,
      ST_FULL
   } state_t;

   typedef struct packed {
      logic       obstacle;
      logic [6:0] left;
      logic [6:0] width;
   } row_t;

endpackage

// File: rtl/tunnel_row_gen_if.sv
// Row stream from the generator to the scroll/render consumer.
interface tunnel_row_gen_if;
   logic       row_valid;
   logic       row_ready;
   logic [6:0] row_left;
   logic [6:0] row_width;
   logic       row_obstacle;

   modport master (output row_valid, row_left, row_width, row_obstacle, input row_ready);
   modport slave  (input row_valid, row_left, row_width, row_obstacle, output row_ready);
endinterface

// File: rtl/tunnel_row_fifo.sv
// First-word-fall-through FIFO; head data reads zero while empty.
module tunnel_row_fifo #(
   parameter  int DEPTH = 4,
   parameter  int W     = 15,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic          do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // a push into a full FIFO is fine when the head leaves on the same edge
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/tunnel_row_gen.sv
// Turns LFSR samples into tunnel rows (left wall, width, obstacle) buffered in a FWFT FIFO.
module tunnel_row_gen
   import tunnel_pkg::*;
#(
   parameter int COLS      = COLS_DEF,
   parameter int MIN_WIDTH = MIN_WIDTH_DEF,
   parameter int MAX_WIDTH = MAX_WIDTH_DEF,
   parameter int DEPTH     = DEPTH_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [7:0]              rnd,
   tunnel_row_gen_if.master        rows
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic signed [7:0] MIN_S  = 8'(MIN_WIDTH);
   localparam logic signed [7:0] MAX_S  = 8'(MAX_WIDTH);
   localparam logic signed [7:0] COLS_S = 8'(COLS);

   state_t     state;
   logic [7:0] rnd_q;
   logic [6:0] cur_left, cur_width;
   row_t       nxt, head;
   logic       push, pop, full, empty;
   logic [CW-1:0] count, cnt_nxt;
   logic signed [7:0] w_try, w_new, l_try, l_max, l_new;

   // Row arithmetic is done signed in 8 bits so a step below zero clamps instead of wrapping
   always_comb begin
      w_try = {1'b0, cur_width};
      case (rnd_q[3:2])
         2'b00:   w_try = w_try - 8'sd1;
         2'b11:   w_try = w_try + 8'sd1;
         default: ;
      endcase
      if (w_try < MIN_S)      w_new = MIN_S;
      else if (w_try > MAX_S) w_new = MAX_S;
      else                    w_new = w_try;

      l_max = COLS_S - w_new;
      l_try = {1'b0, cur_left};
      case (rnd_q[1:0])
         2'b00:   l_try = l_try - 8'sd1;
         2'b10:   l_try = l_try + 8'sd1;
         default: ;
      endcase
      if (l_try < 8'sd0)      l_new = 8'sd0;
      else if (l_try > l_max) l_new = l_max;
      else                    l_new = l_try;

      nxt.width    = w_new[6:0];
      nxt.left     = l_new[6:0];
      nxt.obstacle = (rnd_q[7:4] == 4'hF) && (w_new >= (MIN_S <<< 1));
   end

   assign pop     = !empty && rows.row_ready;
   assign push    = (state == ST_COMPUTE) && (!full || pop);
   assign cnt_nxt = count + CW'(push) - CW'(pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         rnd_q     <= '0;
         cur_width <= 7'(MAX_WIDTH);
         cur_left  <= 7'((COLS - MAX_WIDTH) / 2);
      end else begin
         case (state)
            ST_IDLE:   if (enable) state <= ST_SAMPLE;
            ST_SAMPLE: begin
               rnd_q <= rnd;
               state <= ST_COMPUTE;
            end
            ST_COMPUTE: begin
               if (push) begin
                  cur_width <= nxt.width;
                  cur_left  <= nxt.left;
               end
               if (!enable)                     state <= ST_IDLE;
               else if (cnt_nxt == CW'(DEPTH))  state <= ST_FULL;
               else                             state <= ST_SAMPLE;
            end
            ST_FULL: begin
               if (!enable)   state <= ST_IDLE;
               else if (!full) state <= ST_SAMPLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   tunnel_row_fifo #(.DEPTH(DEPTH), .W(ROW_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (nxt),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign rows.row_valid    = !empty;
   assign rows.row_left     = head.left;
   assign rows.row_width    = head.width;
   assign rows.row_obstacle = head.obstacle;

endmodule

// File: tb/tb_tunnel_row_gen.sv
// Table-driven and scoreboard-checked bench for tunnel_row_gen.
module tb_tunnel_row_gen;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] rnd = 8'h00;

   tunnel_row_gen_if rows();

   tunnel_row_gen dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .rnd    (rnd),
      .rows   (rows)
   );

   always #5 clk = ~clk;

   typedef struct {
      int left;
      int width;
      int obs;
   } exp_t;

   typedef struct {
      logic [7:0] rnd;
      int         idx;
      int         left;
      int         width;
      int         obs;
   } vec_t;

   exp_t sbq[$];
   exp_t last_got;
   int   total = 0;
   int   bad = 0;
   int   pop_cnt = 0;
   int   ml, mw;

   function automatic exp_t model_next(input int l, input int w, input logic [7:0] r);
      exp_t e;
      int   nw, nl;
      nw = w;
      if (r[3:2] == 2'b00) nw = nw - 1;
      else if (r[3:2] == 2'b11) nw = nw + 1;
      if (nw < 16) nw = 16;
      if (nw > 48) nw = 48;
      nl = l;
      if (r[1:0] == 2'b00) nl = nl - 1;
      else if (r[1:0] == 2'b10) nl = nl + 1;
      if (nl < 0) nl = 0;
      if (nl > 80 - nw) nl = 80 - nw;
      e.left  = nl;
      e.width = nw;
      e.obs   = ((r[7:4] == 4'hF) && (nw >= 32)) ? 1 : 0;
      return e;
   endfunction

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic push_rows(input logic [7:0] r, input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e = model_next(ml, mw, r);
         sbq.push_back(e);
         ml = e.left;
         mw = e.width;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // release lands between edges; the first edge afterwards is cycle 1
   task automatic do_reset(input logic [7:0] r, input logic en, input logic rdy);
      reset = 1'b1;
      enable = en;
      rnd = r;
      rows.row_ready = rdy;
      sbq.delete();
      ml = 16;
      mw = 48;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic wait_pops(input int n, input int budget);
      int base, c;
      base = pop_cnt;
      c = 0;
      while ((pop_cnt - base) < n && c < budget) begin
         tick();
         c++;
      end
      if ((pop_cnt - base) < n) begin
         total++;
         bad++;
         $display("FAIL pop_timeout got=%0d want=%0d", pop_cnt - base, n);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && rows.row_valid && rows.row_ready) begin
         exp_t e;
         last_got.left  = int'(rows.row_left);
         last_got.width = int'(rows.row_width);
         last_got.obs   = int'(rows.row_obstacle);
         pop_cnt++;
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_extra_row got_left=%0d got_width=%0d want=none", last_got.left, last_got.width);
         end else begin
            e = sbq.pop_front();
            check("sb_left", last_got.left, e.left);
            check("sb_width", last_got.width, e.width);
            check("sb_obstacle", last_got.obs, e.obs);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      vec_t vt[10];
      int   base;
      vt[0] = '{8'h55,  1, 16, 48, 0};
      vt[1] = '{8'h00,  1, 15, 47, 0};
      vt[2] = '{8'h00, 16,  0, 32, 0};
      vt[3] = '{8'h00, 20,  0, 28, 0};
      vt[4] = '{8'h00, 32,  0, 16, 0};
      vt[5] = '{8'h00, 40,  0, 16, 0};
      vt[6] = '{8'h0E,  1, 17, 48, 0};
      vt[7] = '{8'h0E, 16, 32, 48, 0};
      vt[8] = '{8'h0E, 20, 32, 48, 0};
      vt[9] = '{8'hF5,  1, 16, 48, 1};

      rows.row_ready = 1'b0;
      repeat (2) tick();
      check("reset_valid", int'(rows.row_valid), 0);
      check("reset_left", int'(rows.row_left), 0);
      check("reset_width", int'(rows.row_width), 0);
      check("reset_obstacle", int'(rows.row_obstacle), 0);

      // fill with no consumer: first row visible on cycle 3, then FSM parks in FULL
      do_reset(8'h55, 1'b1, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         check($sformatf("valid_cycle%0d", k), int'(rows.row_valid), (k == 3) ? 1 : 0);
      end
      repeat (12) tick();
      push_rows(8'h55, 4);
      enable = 1'b0;
      repeat (2) tick();
      base = pop_cnt;
      rows.row_ready = 1'b1;
      wait_pops(4, 20);
      repeat (6) tick();
      rows.row_ready = 1'b0;
      check("full_hold_rows", pop_cnt - base, 4);
      check("full_drained_valid", int'(rows.row_valid), 0);

      foreach (vt[i]) begin
         do_reset(vt[i].rnd, 1'b1, 1'b1);
         push_rows(vt[i].rnd, vt[i].idx);
         wait_pops(vt[i].idx, 4 * vt[i].idx + 20);
         rows.row_ready = 1'b0;
         check($sformatf("vec%0d_left", i), last_got.left, vt[i].left);
         check($sformatf("vec%0d_width", i), last_got.width, vt[i].width);
         check($sformatf("vec%0d_obstacle", i), last_got.obs, vt[i].obs);
      end

      // single pop from FULL: one slot refilled, nothing lost or duplicated
      do_reset(8'h0E, 1'b1, 1'b0);
      push_rows(8'h0E, 5);
      repeat (12) tick();
      base = pop_cnt;
      rows.row_ready = 1'b1;
      tick();
      rows.row_ready = 1'b0;
      check("one_pop_count", pop_cnt - base, 1);
      check("one_pop_left", last_got.left, 17);
      repeat (10) tick();
      enable = 1'b0;
      repeat (3) tick();
      base = pop_cnt;
      rows.row_ready = 1'b1;
      wait_pops(4, 30);
      repeat (4) tick();
      rows.row_ready = 1'b0;
      check("refill_rows", pop_cnt - base, 4);
      check("refill_last_left", last_got.left, 21);
      check("refill_queue_left", sbq.size(), 0);

      // enable dropped mid-stream, then obstacle rnd at minimum width
      do_reset(8'h00, 1'b1, 1'b1);
      push_rows(8'h00, 40);
      wait_pops(34, 200);
      enable = 1'b0;
      repeat (8) tick();
      rows.row_ready = 1'b0;
      check("drop_en_valid", int'(rows.row_valid), 0);
      check("drop_en_width", last_got.width, 16);
      check("drop_en_left", last_got.left, 0);
      sbq.delete();
      ml = last_got.left;
      mw = last_got.width;
      rnd = 8'hF5;
      push_rows(8'hF5, 3);
      enable = 1'b1;
      rows.row_ready = 1'b1;
      wait_pops(3, 30);
      rows.row_ready = 1'b0;
      check("narrow_obstacle", last_got.obs, 0);
      check("narrow_width", last_got.width, 16);
      check("narrow_left", last_got.left, 0);

      // reset with 3 rows buffered and the FSM in COMPUTE
      do_reset(8'h0E, 1'b1, 1'b0);
      repeat (8) tick();
      check("pre_reset_valid", int'(rows.row_valid), 1);
      check("pre_reset_head_left", int'(rows.row_left), 17);
      reset = 1'b1;
      #1;
      check("mid_reset_valid", int'(rows.row_valid), 0);
      check("mid_reset_left", int'(rows.row_left), 0);
      check("mid_reset_width", int'(rows.row_width), 0);
      check("mid_reset_obstacle", int'(rows.row_obstacle), 0);
      sbq.delete();
      ml = 16;
      mw = 48;
      rnd = 8'h55;
      push_rows(8'h55, 1);
      tick();
      reset = 1'b0;
      rows.row_ready = 1'b1;
      wait_pops(1, 20);
      rows.row_ready = 1'b0;
      check("post_reset_left", last_got.left, 16);
      check("post_reset_width", last_got.width, 48);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
